// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit unsigned adder built on an internal
// 4-bit add-with-carry slice. Operands are processed one nibble per clock from the
// least-significant end. The slice carry-out is registered and fed back as the
// carry-in of the next nibble.
//
// Optional feature macro: NIBBLE_SERIAL_OVF_EN (adds a signed-overflow output ovf).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   add request, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   cin    in   initial carry-in, captured on an accepted start
//   busy   out  high while an add is in progress (RUN and DONE)
//   done   out  one-cycle pulse; s/c (and ovf) are valid from this cycle
//   s      out  sum register, holds the last result
//   c      out  final carry-out register
//   ovf    out  signed overflow of the last result (only with NIBBLE_SERIAL_OVF_EN)
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
`ifdef NIBBLE_SERIAL_OVF_EN
  output logic             c,
  output logic             ovf
`else
  output logic             c
`endif
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [4:0]       w_sum5;
  logic [3:0]       w_sum4;
  logic             w_co;
  logic [WIDTH-1:0] w_s_sh_nxt;
  logic             w_last;
  logic             w_busy_d;
  logic             w_done_d;

  // 4-bit add-with-carry slice on the low nibble of the operand shifters
  assign w_sum5     = 5'(r_a_sh[3:0]) + 5'(r_b_sh[3:0]) + 5'(r_carry);
  assign w_sum4     = w_sum5[3:0];
  assign w_co       = w_sum5[4];
  assign w_s_sh_nxt = {w_sum4, r_s_sh[WIDTH-1:4]};
  assign w_last     = (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: busy/done are registered against the state being entered
  always_comb begin
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    case (w_state_nxt)
      S_RUN:   w_busy_d = 1'b1;
      S_DONE: begin
        w_busy_d = 1'b1;
        w_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= w_busy_d;
      done <= w_done_d;
    end
  end

  // Datapath: operand capture, nibble shifting, result capture on the final slice
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      s       <= '0;
      c       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_s_sh  <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a_sh  <= {4'b0000, r_a_sh[WIDTH-1:4]};
          r_b_sh  <= {4'b0000, r_b_sh[WIDTH-1:4]};
          r_s_sh  <= w_s_sh_nxt;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Result must include the slice computed in this same cycle
          if (w_last) begin
            s <= w_s_sh_nxt;
            c <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_OVF_EN
  logic w_c_into_msb;

  // Carry into bit 3 of the top nibble recovered from its sum bit
  assign w_c_into_msb = r_a_sh[3] ^ r_b_sh[3] ^ w_sum4[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      ovf <= w_c_into_msb ^ w_co;
    end
  end
`endif

endmodule
